// File: rtl/max_pulse_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : max_pulse_sched_pkg
//  Purpose  : Shared types and helpers for the two-channel max/pulse
//             scheduler: FSM state codes, channel ids and the round-robin
//             grant decision.
//  Revision : 1.0  initial release
// ============================================================================
package max_pulse_sched_pkg;

  // STAR encoding; code 2'd3 is unused and recovered to IDLE by the FSM.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_PULSE = 2'd2
  } state_e;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_e;

  // Round-robin pick. `last` is the channel served most recently; on a
  // simultaneous request the other channel wins. Only meaningful when at
  // least one request is present.
  function automatic chan_e rr_pick(input logic req_a,
                                    input logic req_b,
                                    input chan_e last);
    chan_e pick;
    if (req_a && req_b) begin
      pick = (last == CH_A) ? CH_B : CH_A;
    end else if (req_b) begin
      pick = CH_B;
    end else begin
      pick = CH_A;
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/max_unit.sv
`default_nettype none
// ============================================================================
//  Module   : max_unit
//  Purpose  : Combinational unsigned maximum of two N-bit operands.
//             Ties return x.
//  Revision : 1.0  initial release
//  Ports    : x   in  N  operand x
//             y   in  N  operand y
//             max out N  (x < y) ? y : x
// ============================================================================
module max_unit #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] max
);

  localparam logic [N:0] ONE_W = {{N{1'b0}}, 1'b1};

  logic carry;
  logic borrow;

  // x - y computed as x + ~y + 1 on N+1 bits; the carry out is 1 when
  // x >= y, so its inverse is the borrow that flags x < y.
  assign carry  = |(({1'b0, x} + {1'b0, ~y} + ONE_W) >> N);
  assign borrow = ~carry;
  assign max    = borrow ? y : x;

endmodule
`default_nettype wire

// File: rtl/max_pulse_sched.sv
`default_nettype none
// ============================================================================
//  Module   : max_pulse_sched
//  Purpose  : Two-channel round-robin scheduler sharing one unsigned max
//             comparator and one pulse output. A granted channel's
//             max(x,y) is latched and then `out` is driven high for exactly
//             that many clock periods.
//  Revision : 1.0  initial release
//  Ports    : clock   in   1  system clock, posedge active
//             reset_  in   1  asynchronous active-low reset
//             dav_a_  in   1  channel A data valid, active-low
//             rfd_a   out  1  channel A ready-for-data
//             xa, ya  in   N  channel A operands
//             dav_b_  in   1  channel B data valid, active-low
//             rfd_b   out  1  channel B ready-for-data
//             xb, yb  in   N  channel B operands
//             out     out  1  pulse output
//             chan    out  1  owner of current/last transaction (0=A, 1=B)
// ============================================================================
module max_pulse_sched
  import max_pulse_sched_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         dav_a_,
  output logic         rfd_a,
  input  logic [N-1:0] xa,
  input  logic [N-1:0] ya,
  input  logic         dav_b_,
  output logic         rfd_b,
  input  logic [N-1:0] xb,
  input  logic [N-1:0] yb,
  output logic         out,
  output logic         chan
);

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  state_e       star_q;
  logic [N-1:0] count_q;
  logic         rfd_a_q;
  logic         rfd_b_q;
  logic         out_q;
  chan_e        chan_q;
  chan_e        ptr_q;

  logic         req_a;
  logic         req_b;
  chan_e        gnt;
  logic [N-1:0] op_x;
  logic [N-1:0] op_y;
  logic [N-1:0] max_val;
  logic         own_dav_n;

  assign req_a = ~dav_a_;
  assign req_b = ~dav_b_;
  assign gnt   = rr_pick(req_a, req_b, ptr_q);

  // Operand mux ahead of the single comparator so COUNT is loaded in the
  // same edge that issues the grant.
  assign op_x = (gnt == CH_B) ? xb : xa;
  assign op_y = (gnt == CH_B) ? yb : ya;

  max_unit #(.N(N)) u_max (
    .x   (op_x),
    .y   (op_y),
    .max (max_val)
  );

  // Data-valid of whichever channel currently owns the transaction.
  assign own_dav_n = (chan_q == CH_B) ? dav_b_ : dav_a_;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      star_q  <= ST_IDLE;
      count_q <= '0;
      rfd_a_q <= 1'b1;
      rfd_b_q <= 1'b1;
      out_q   <= 1'b0;
      chan_q  <= CH_A;
      ptr_q   <= CH_A;
    end else begin
      case (star_q)
        ST_IDLE: begin
          rfd_a_q <= 1'b1;
          rfd_b_q <= 1'b1;
          out_q   <= 1'b0;
          if (req_a || req_b) begin
            count_q <= max_val;
            chan_q  <= gnt;
            ptr_q   <= gnt;
            if (gnt == CH_A) begin
              rfd_a_q <= 1'b0;
            end else begin
              rfd_b_q <= 1'b0;
            end
            star_q <= ST_ACK;
          end
        end

        ST_ACK: begin
          // Producer must drop its valid before anything is emitted.
          if (own_dav_n) begin
            if (count_q == '0) begin
              if (chan_q == CH_A) begin
                rfd_a_q <= 1'b1;
              end else begin
                rfd_b_q <= 1'b1;
              end
              star_q <= ST_IDLE;
            end else begin
              out_q  <= 1'b1;
              star_q <= ST_PULSE;
            end
          end
        end

        ST_PULSE: begin
          count_q <= count_q - ONE_N;
          // <= rather than == keeps a corrupted zero from wrapping.
          if (count_q <= ONE_N) begin
            out_q <= 1'b0;
            if (chan_q == CH_A) begin
              rfd_a_q <= 1'b1;
            end else begin
              rfd_b_q <= 1'b1;
            end
            star_q <= ST_IDLE;
          end
        end

        default: begin
          // Unused state code: drop to a clean idle on the next edge.
          out_q   <= 1'b0;
          rfd_a_q <= 1'b1;
          rfd_b_q <= 1'b1;
          star_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign rfd_a = rfd_a_q;
  assign rfd_b = rfd_b_q;
  assign out   = out_q;
  assign chan  = chan_q;

endmodule
`default_nettype wire

// File: tb/tb_max_pulse_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_max_pulse_sched
//  Purpose  : Scoreboard bench for max_pulse_sched. Producers push the
//             expected pulse length per channel; a negedge monitor models
//             the arbitration rules and checks grants, latency, pulse length
//             and the handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_max_pulse_sched;

  localparam int N = 8;

  logic         clock  = 1'b0;
  logic         reset_ = 1'b1;
  logic         dav_a_ = 1'b1;
  logic         dav_b_ = 1'b1;
  logic [N-1:0] xa = '0, ya = '0, xb = '0, yb = '0;
  logic         rfd_a, rfd_b, out, chan;

  always #5 clock = ~clock;

  max_pulse_sched #(.N(N)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .dav_a_ (dav_a_),
    .rfd_a  (rfd_a),
    .xa     (xa),
    .ya     (ya),
    .dav_b_ (dav_b_),
    .rfd_b  (rfd_b),
    .xb     (xb),
    .yb     (yb),
    .out    (out),
    .chan   (chan)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pulse lengths per channel, in request order.
  int qa[$];
  int qb[$];

  // Producer state: 0 idle, 1 waiting grant, 2 holding valid, 3 waiting rfd.
  int pst[2];
  int hold[2];

  task automatic set_dav(input int c, input logic v);
    if (c == 0) dav_a_ = v; else dav_b_ = v;
  endtask

  task automatic req(input int c, input int x, input int y, input int h);
    int m;
    m = (x > y) ? x : y;
    if (c == 0) begin xa = x[N-1:0]; ya = y[N-1:0]; qa.push_back(m); end
    else        begin xb = x[N-1:0]; yb = y[N-1:0]; qb.push_back(m); end
    set_dav(c, 1'b0);
    pst[c]  = 1;
    hold[c] = h;
  endtask

  // Advance one clock and let the producers react to rfd.
  task automatic step();
    logic rr;
    @(posedge clock);
    #1;
    for (int c = 0; c < 2; c++) begin
      rr = (c == 0) ? rfd_a : rfd_b;
      case (pst[c])
        1: if (!rr) begin
             if (hold[c] == 0) begin set_dav(c, 1'b1); pst[c] = 3; end
             else begin hold[c]--; pst[c] = 2; end
           end
        2: if (hold[c] == 0) begin set_dav(c, 1'b1); pst[c] = 3; end
           else hold[c]--;
        3: if (rr) pst[c] = 0;
        default: ;
      endcase
    end
  endtask

  // ---------------- monitor / reference model ----------------
  bit m_busy = 0;
  int m_cur  = 0;
  int m_last = 0;
  int m_exp  = 0;
  int m_cnt  = 0;
  int m_wd   = 0;
  bit m_rel  = 0;
  bit p_rfd[2] = '{1, 1};
  bit p_dav[2] = '{1, 1};

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while ((pst[0] != 0 || pst[1] != 0 || m_busy) && k < limit) begin
      step();
      k++;
    end
    if (k >= limit) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: waited %0d cycles, limit %0d", k, limit);
    end
  endtask

  always @(negedge clock) begin
    bit r[2];
    bit d[2];
    int e;
    r[0] = rfd_a; r[1] = rfd_b;
    d[0] = dav_a_; d[1] = dav_b_;
    if (!reset_) begin
      m_busy = 0;
      m_last = 0;
      qa.delete();
      qb.delete();
    end else if (!m_busy) begin
      check("idle_out", out, 0);
      if (p_rfd[0] && p_rfd[1] && (!p_dav[0] || !p_dav[1])) begin
        if (!p_dav[0] && !p_dav[1]) e = 1 - m_last;
        else e = (!p_dav[0]) ? 0 : 1;
        check("grant_rfd", r[e], 0);
        check("other_rfd", r[1-e], 1);
        check("grant_chan", chan, e);
        if ((e == 0 && qa.size() == 0) || (e == 1 && qb.size() == 0)) begin
          n_cmp++;
          n_fail++;
          $display("FAIL grant_no_request: got grant on chan %0d, expected none", e);
          m_exp = 0;
        end else begin
          m_exp = (e == 0) ? qa.pop_front() : qb.pop_front();
        end
        m_busy = 1; m_cur = e; m_last = e;
        m_cnt = 0; m_wd = 0; m_rel = 0;
      end
    end else begin
      m_wd++;
      check("other_rfd_busy", r[1-m_cur], 1);
      check("chan_hold", chan, m_cur);
      if (!m_rel) begin
        if (p_dav[m_cur]) begin
          m_rel = 1;
          if (m_exp > 0) check("pulse_latency", out, 1);
          else           check("zero_done_latency", r[m_cur], 1);
        end else begin
          check("ack_hold_out", out, 0);
        end
      end
      if (out) m_cnt++;
      if (r[m_cur]) begin
        check("pulse_len", m_cnt, m_exp);
        check("done_out", out, 0);
        m_busy = 0;
      end else if (m_wd > 600) begin
        n_cmp++;
        n_fail++;
        $display("FAIL txn_timeout: busy %0d cycles, limit 600", m_wd);
        m_busy = 0;
      end
    end
    p_rfd = r;
    p_dav = d;
  end

  // ---------------- stimulus ----------------
  function automatic int rand_op();
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return 0;
    if (s == 1) return 255;
    return $urandom_range(0, 20);
  endfunction

  initial begin
    int k;
    pst[0] = 0; pst[1] = 0; hold[0] = 0; hold[1] = 0;

    // Reset state, observed without a clock edge.
    #2 reset_ = 1'b0;
    #1;
    check("reset_rfd_a", rfd_a, 1);
    check("reset_rfd_b", rfd_b, 1);
    check("reset_out", out, 0);
    check("reset_chan", chan, 0);
    repeat (2) @(posedge clock);
    #1 reset_ = 1'b1;

    // A alone, max(5,9)=9.
    req(0, 5, 9, 0);
    wait_idle(200);

    // Simultaneous: last served was A, so B goes first.
    req(0, 4, 4, 0);
    req(1, 3, 2, 0);
    wait_idle(200);

    // Zero-length transaction.
    req(0, 0, 0, 0);
    wait_idle(200);

    // Full-scale count.
    req(1, 255, 254, 0);
    wait_idle(600);

    // Reset in the middle of a B pulse of 10.
    req(1, 10, 3, 0);
    k = 0;
    while (!out && k < 20) begin step(); k++; end
    check("reset_test_pulse_started", out, 1);
    repeat (3) step();
    #2 reset_ = 1'b0;
    #1;
    check("abort_out", out, 0);
    check("abort_rfd_a", rfd_a, 1);
    check("abort_rfd_b", rfd_b, 1);
    check("abort_chan", chan, 0);
    pst[0] = 0; pst[1] = 0;
    dav_a_ = 1'b1; dav_b_ = 1'b1;
    step();
    step();
    reset_ = 1'b1;
    req(0, 7, 2, 0);
    wait_idle(200);

    // Valid held low for 6 clocks after grant.
    req(0, 2, 6, 6);
    wait_idle(200);

    // Randomized traffic on both channels.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (pst[c] == 0 && $urandom_range(0, 5) == 0)
          req(c, rand_op(), rand_op(), $urandom_range(0, 3));
      end
      step();
    end
    wait_idle(2000);

    check("leftover_a", qa.size(), 0);
    check("leftover_b", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
